iter_shifter: RTL and testbench

ITER_SHIFTER -- requirements
Module: iter_shifter

---
 rtl/iter_shifter_pkg.sv | 24 ++
 rtl/iter_shifter.sv | 113 +++++++++++
 tb/tb_iter_shifter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/iter_shifter_pkg.sv
// iter_shifter_pkg
// Shared definitions for the iterative shifter:
//   XLEN        - default datapath width
//   shift_op_e  - operation encoding; identical to the ShiftControl bus
//                 driven by the control unit, so the bus can be cast directly
//   state_e     - FSM state encoding (IDLE, SHIFT, DONE)
package iter_shifter_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        NOP = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/iter_shifter.sv
// iter_shifter
// Multi-cycle shifter: one bit position per clock.  An accepted start
// captures the operand, the shift amount and the operation.  The FSM then
// walks the work register one bit per SHIFT cycle, and pulses done for one
// cycle with the result.  Zero-length shifts and the reserved operation
// skip SHIFT and pass the operand straight through.
//
// Ports
//   clk           in   clock, all state on rising edge
//   reset_n       in   asynchronous active-low reset
//   start         in   shift request, only looked at in IDLE
//   ShiftControl  in   2  00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   data_in       in   XLEN operand
//   shamt         in   6  shift amount
//   busy          out  high while SHIFT or DONE
//   done          out  single-cycle pulse, result valid
//   result        out  XLEN result, held until the next completion
module iter_shifter #(
    parameter int XLEN = iter_shifter_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      ShiftControl,
    input  logic [XLEN-1:0] data_in,
    input  logic [5:0]      shamt,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import iter_shifter_pkg::*;

    state_e          state_reg,  state_next;
    logic [XLEN-1:0] work_reg,   work_next;
    logic [5:0]      cnt_reg,    cnt_next;
    shift_op_e       op_reg,     op_next;
    logic [XLEN-1:0] result_reg, result_next;

    // Single one-bit step of the selected operation.
    function automatic logic [XLEN-1:0] shift_step(input logic [XLEN-1:0] v,
                                                   input shift_op_e op);
        logic [XLEN-1:0] r;
        case (op)
            SLL:     r = {v[XLEN-2:0], 1'b0};
            SRL:     r = {1'b0, v[XLEN-1:1]};
            SRA:     r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        state_next  = state_reg;
        work_next   = work_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        result_next = result_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    work_next = data_in;
                    cnt_next  = shamt;
                    op_next   = shift_op_e'(ShiftControl);
                    if (shamt == 6'd0 || ShiftControl == 2'b11) begin
                        state_next  = ST_DONE;
                        result_next = data_in;
                    end else begin
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_next = shift_step(work_reg, op_reg);
                cnt_next  = cnt_reg - 6'd1;
                // The last shift happens in the same cycle as the exit, so
                // the result register is loaded with the post-shift value.
                if (cnt_reg == 6'd1) begin
                    state_next  = ST_DONE;
                    result_next = work_next;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            work_reg   <= '0;
            cnt_reg    <= '0;
            op_reg     <= SLL;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            work_reg   <= work_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            result_reg <= result_next;
        end
    end

    // Status is decoded from the state register alone, so start never
    // reaches busy or done combinationally.
    assign busy   = (state_reg != ST_IDLE);
    assign done   = (state_reg == ST_DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter
// Directed vector table plus randomized operations for iter_shifter, with
// hand-written sequences for start-while-busy, reset mid-shift and
// back-to-back operation.  Expected results come from whole-word shift
// arithmetic; expected latency is the number of rising edges after the
// accepting edge before done is seen (0 for the direct pass-through path).
module tb_iter_shifter;
    localparam int XLEN = 64;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic [1:0]      ShiftControl;
    logic [XLEN-1:0] data_in;
    logic [5:0]      shamt;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int n_checks;
    int n_fail;
    int done_count;

    iter_shifter #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .ShiftControl (ShiftControl),
        .data_in      (data_in),
        .shamt        (shamt),
        .busy         (busy),
        .done         (done),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_count++;

    typedef struct {
        logic [XLEN-1:0] d;
        logic [1:0]      op;
        logic [5:0]      sh;
        logic [XLEN-1:0] exp;
        int              lat;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [XLEN-1:0] ref_shift(input logic [XLEN-1:0] d,
                                                  input logic [1:0] op,
                                                  input logic [5:0] sh);
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return XLEN'($signed(d) >>> sh);
            default: return d;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [5:0] sh);
        return (sh == 6'd0 || op == 2'b11) ? 0 : int'(sh);
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at #1 after an accepting edge; polls until done or budget.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Called at #1 after a posedge with the DUT idle; returns one cycle
    // after DONE (back in IDLE).
    task automatic do_op(input logic [XLEN-1:0] d, input logic [1:0] op,
                         input logic [5:0] sh, output logic [XLEN-1:0] res,
                         output int lat, output bit ok);
        data_in = d; ShiftControl = op; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: the captured operation must not notice.
        data_in = {$urandom, $urandom};
        ShiftControl = 2'($urandom);
        shamt = 6'($urandom);
        check("busy_after_accept", 64'(busy), 64'd1);
        wait_done(lat, ok);
        res = result;
        @(posedge clk); #1;
    endtask

    task automatic run_checked(input string tag, input logic [XLEN-1:0] d,
                               input logic [1:0] op, input logic [5:0] sh,
                               input logic [XLEN-1:0] exp, input int exp_lat);
        logic [XLEN-1:0] res;
        int lat, dc0;
        bit ok;
        dc0 = done_count;
        do_op(d, op, sh, res, lat, ok);
        check({tag, "_timeout"}, 64'(ok), 64'd1);
        check({tag, "_result"}, res, exp);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_pulses"}, 64'(done_count - dc0), 64'd1);
        check({tag, "_held"}, result, exp);
        check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
        $display("op %s d=%h op=%0d sh=%0d res=%h lat=%0d", tag, d, op, sh, res, lat);
    endtask

    initial begin
        logic [XLEN-1:0] d, exp;
        logic [1:0] op;
        logic [5:0] sh;
        int lat, dc0;
        bit ok;

        n_checks = 0; n_fail = 0; done_count = 0;
        reset_n = 1'b0; start = 1'b0; ShiftControl = 2'b00;
        data_in = '0; shamt = '0;

        vecs[0] = '{64'h1, 2'b00, 6'd4, 64'h10, 4};
        vecs[1] = '{64'h8000_0000_0000_0000, 2'b10, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 63};
        vecs[2] = '{64'h8000_0000_0000_0000, 2'b01, 6'd63, 64'h1, 63};
        vecs[3] = '{64'hDEAD_BEEF, 2'b00, 6'd0, 64'hDEAD_BEEF, 0};
        vecs[4] = '{64'hDEAD_BEEF, 2'b11, 6'd5, 64'hDEAD_BEEF, 0};
        vecs[5] = '{64'hF0, 2'b01, 6'd1, 64'h78, 1};
        vecs[6] = '{64'h4000_0000_0000_0000, 2'b10, 6'd62, 64'h1, 62};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 6'd63, 64'h8000_0000_0000_0000, 63};
        vecs[8] = '{64'h8000_0000_0000_0001, 2'b10, 6'd1, 64'hC000_0000_0000_0000, 1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 64'd0);
        check("reset_flags", {62'd0, busy, done}, 64'd0);
        reset_n = 1'b1;

        // Table vectors; the first one starts right after reset release.
        for (int i = 0; i < 9; i++)
            run_checked($sformatf("vec%0d", i), vecs[i].d, vecs[i].op,
                        vecs[i].sh, vecs[i].exp, vecs[i].lat);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            d  = {$urandom, $urandom};
            op = 2'($urandom_range(0, 3));
            sh = (i % 5 == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            run_checked($sformatf("rnd%0d", i), d, op, sh,
                        ref_shift(d, op, sh), ref_lat(op, sh));
        end

        // Start pulsed mid-shift with different operands is ignored.
        dc0 = done_count;
        data_in = 64'h1234_5678_9ABC_DEF0; ShiftControl = 2'b01; shamt = 6'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        data_in = 64'hFFFF_0000_FFFF_0000; ShiftControl = 2'b00; shamt = 6'd2;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, ok);
        check("busy_start_timeout", 64'(ok), 64'd1);
        check("busy_start_result", result, 64'h0012_3456_789A_BCDE);
        repeat (3) @(posedge clk);
        #1;
        check("busy_start_pulses", 64'(done_count - dc0), 64'd1);
        check("busy_start_held", result, 64'h0012_3456_789A_BCDE);
        $display("op busy_start res=%h", result);

        // Reset in the middle of a 10-bit shift.
        dc0 = done_count;
        data_in = 64'h3; ShiftControl = 2'b00; shamt = 6'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset_result", result, 64'd0);
        check("midreset_flags", {62'd0, busy, done}, 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check("midreset_no_done", 64'(done_count - dc0), 64'd0);
        reset_n = 1'b1;
        $display("op midreset res=%h", result);
        run_checked("after_reset", 64'h3, 2'b00, 6'd10, 64'hC00, 10);

        // Back-to-back: start in DONE ignored, start in next IDLE accepted.
        dc0 = done_count;
        data_in = 64'h5; ShiftControl = 2'b00; shamt = 6'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, ok);
        check("b2b_first_timeout", 64'(ok), 64'd1);
        check("b2b_first_result", result, 64'h28);
        data_in = 64'hAAAA; ShiftControl = 2'b01; shamt = 6'd2;   // DONE cycle
        start = 1'b1;
        @(posedge clk); #1;
        data_in = 64'h7; ShiftControl = 2'b00; shamt = 6'd5;      // IDLE cycle
        @(posedge clk); #1;
        start = 1'b0;
        exp = ref_shift(64'h7, 2'b00, 6'd5);
        wait_done(lat, ok);
        check("b2b_second_timeout", 64'(ok), 64'd1);
        check("b2b_second_result", result, exp);
        check("b2b_second_latency", 64'(lat), 64'(ref_lat(2'b00, 6'd5)));
        repeat (3) @(posedge clk);
        #1;
        check("b2b_pulses", 64'(done_count - dc0), 64'd2);
        $display("op b2b res=%h", result);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
